// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   - arb_state_t : arbiter FSM state encoding
//   - REQ_CPU/REQ_LDR : requester index constants
//   - DEF_ADDR_W/DEF_DATA_W : default memory geometry (64 x 16)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam int unsigned REQ_CPU = 0;
  localparam int unsigned REQ_LDR = 1;

  localparam int unsigned DEF_ADDR_W = 6;
  localparam int unsigned DEF_DATA_W = 16;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way round-robin picker with lock masking.
// Ports:
//   req        in  per-requester request
//   lock_valid in  a lock is held; only lock_owner may be served
//   lock_owner in  requester holding the lock
//   last       in  requester granted most recently
//   any        out at least one requester is eligible
//   winner     out index of the selected requester (valid when any=1)
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lock_valid,
  input  logic       lock_owner,
  input  logic       last,
  output logic       any,
  output logic       winner
);

  logic [1:0] w_elig;

  always_comb begin
    w_elig = req;
    if (lock_valid) begin
      w_elig             = '0;
      w_elig[lock_owner] = req[lock_owner];
    end
    any = |w_elig;
    // On a tie the requester not served last wins; otherwise the lone
    // eligible requester is simply whether the loader bit is set.
    if (&w_elig)
      winner = ~last;
    else
      winner = w_elig[REQ_LDR];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read 64x16 memory between the CPU port (0) and the
// loader/debug port (1). Round-robin arbitration with an optional lock that
// keeps the memory with one requester across consecutive accesses.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   req, lock, we         per-requester request, lock and write enable
//   addr0/1, wdata0/1     per-requester address and write data
//   gnt, ack              one-cycle one-hot grant and completion pulses
//   rdata                 read data, valid with ack of a read
//   mem_en, mem_we        memory strobe and write enable
//   mem_addr, mem_wdata   memory command address and write data
//   mem_rdata             memory read data, one cycle after a read strobe
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        lock,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        r_state;
  logic              r_last;
  logic              r_lock_valid;
  logic              r_lock_owner;
  logic              r_owner;
  logic              r_is_read;
  logic [1:0]        r_gnt;
  logic [1:0]        r_ack;
  logic [DATA_W-1:0] r_rdata;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_any;
  logic              w_winner;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_we;
  logic              w_lock;

  mem_arb_pick u_pick (
    .req        (req),
    .lock_valid (r_lock_valid),
    .lock_owner (r_lock_owner),
    .last       (r_last),
    .any        (w_any),
    .winner     (w_winner)
  );

  always_comb begin
    w_addr  = w_winner ? addr1  : addr0;
    w_wdata = w_winner ? wdata1 : wdata0;
    w_we    = we[w_winner];
    w_lock  = lock[w_winner];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last       <= 1'b1;
      r_lock_valid <= 1'b0;
      r_lock_owner <= 1'b0;
      r_owner      <= 1'b0;
      r_is_read    <= 1'b0;
      r_gnt        <= '0;
      r_ack        <= '0;
      r_rdata      <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // ack from the previous RESP drops here, even if a new grant is
          // issued on the same edge.
          r_ack <= '0;
          if (w_any) begin
            r_mem_en          <= 1'b1;
            r_mem_we          <= w_we;
            r_mem_addr        <= w_addr;
            r_mem_wdata       <= w_wdata;
            r_gnt             <= '0;
            r_gnt[w_winner]   <= 1'b1;
            r_last            <= w_winner;
            r_owner           <= w_winner;
            r_is_read         <= ~w_we;
            r_lock_valid      <= w_lock;
            if (w_lock)
              r_lock_owner <= w_winner;
            r_state           <= ISSUE;
          end else if (r_lock_valid && !req[r_lock_owner] && !lock[r_lock_owner]) begin
            r_lock_valid <= 1'b0;
          end
        end
        ISSUE: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          r_gnt    <= '0;
          r_state  <= RESP;
        end
        RESP: begin
          r_ack[r_owner] <= 1'b1;
          if (r_is_read)
            r_rdata <= mem_rdata;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign ack       = r_ack;
  assign rdata     = r_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 64x16 synchronous
// memory and a backdoor preload path.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req   = '0;
  logic [1:0]  lock  = '0;
  logic [1:0]  we    = '0;
  logic [5:0]  addr0 = '0;
  logic [5:0]  addr1 = '0;
  logic [15:0] wdata0 = '0;
  logic [15:0] wdata1 = '0;
  logic [1:0]  gnt;
  logic [1:0]  ack;
  logic [15:0] rdata;
  logic        mem_en;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;

  logic [15:0] mem [64];
  logic        bd_we   = 1'b0;
  logic [5:0]  bd_addr = '0;
  logic [15:0] bd_data = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mem_port_arbiter #(.ADDR_W(6), .DATA_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .lock      (lock),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt       (gnt),
    .ack       (ack),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bd_we)
      mem[bd_addr] <= bd_data;
    else if (mem_en) begin
      if (mem_we)
        mem[mem_addr] <= mem_wdata;
      else
        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic poke(input logic [5:0] a, input logic [15:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    tick();
    bd_we   = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Single non-locked access; waits (bounded) for gnt then ack.
  task automatic do_access(input int r, input logic w, input logic [5:0] a,
                           input logic [15:0] d, output logic [15:0] rd);
    bit seen;
    if (r == 0) begin addr0 = a; wdata0 = d; end
    else        begin addr1 = a; wdata1 = d; end
    we[r]  = w;
    req[r] = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      tick();
      if (gnt[r]) seen = 1'b1;
    end
    chk("acc_gnt_seen", 32'(seen), 32'd1);
    req[r] = 1'b0;
    we[r]  = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      tick();
      if (ack[r]) seen = 1'b1;
    end
    chk("acc_ack_seen", 32'(seen), 32'd1);
    rd = rdata;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    int last_ack;

    #1;
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);

    // Single read of mem[5]=3 by requester 0
    poke(6'd5, 16'd3);
    addr0 = 6'd5; we = 2'b00; req = 2'b01;
    tick();
    chk("rd_gnt", 32'(gnt), 32'h1);
    chk("rd_mem_en", 32'(mem_en), 32'd1);
    chk("rd_mem_we", 32'(mem_we), 32'd0);
    chk("rd_mem_addr", 32'(mem_addr), 32'd5);
    req = 2'b00;
    tick();
    chk("rd_issue_gnt", 32'(gnt), 32'd0);
    chk("rd_issue_en", 32'(mem_en), 32'd0);
    chk("rd_issue_ack", 32'(ack), 32'd0);
    tick();
    chk("rd_ack", 32'(ack), 32'h1);
    chk("rd_rdata", 32'(rdata), 32'd3);
    tick();
    chk("rd_ack_clear", 32'(ack), 32'd0);

    // Requester 1 writes 0C37 to 22 then reads it back
    addr1 = 6'd22; wdata1 = 16'h0C37; we = 2'b10; req = 2'b10;
    tick();
    chk("wr_gnt", 32'(gnt), 32'h2);
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_addr", 32'(mem_addr), 32'd22);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'h0C37);
    req = 2'b00; we = 2'b00;
    tick();
    tick();
    chk("wr_ack", 32'(ack), 32'h2);
    chk("wr_rdata_kept", 32'(rdata), 32'd3);
    req = 2'b10;
    tick();
    chk("wr_rd_gnt_b2b", 32'(gnt), 32'h2);
    chk("wr_rd_ack_clear", 32'(ack), 32'd0);
    req = 2'b00;
    tick();
    tick();
    chk("wr_rd_ack", 32'(ack), 32'h2);
    chk("wr_rd_rdata", 32'(rdata), 32'h0C37);

    // Tie: both request continuously, grants alternate starting with 0
    do_reset();
    addr0 = 6'd1; addr1 = 6'd2; we = 2'b00; req = 2'b11;
    tick();
    chk("tie_g0", 32'(gnt), 32'h1);
    chk("tie_a0", 32'(mem_addr), 32'd1);
    tick(); tick(); tick();
    chk("tie_g1", 32'(gnt), 32'h2);
    chk("tie_a1", 32'(mem_addr), 32'd2);
    tick(); tick(); tick();
    chk("tie_g2", 32'(gnt), 32'h1);
    tick(); tick(); tick();
    chk("tie_g3", 32'(gnt), 32'h2);
    req = 2'b00;
    tick(); tick();
    chk("tie_last_ack", 32'(ack), 32'h2);

    // Lock: requester 0 locked write then unlocked read before requester 1
    do_reset();
    addr0 = 6'd0; wdata0 = 16'hAAAA; addr1 = 6'd0;
    we = 2'b01; lock = 2'b01; req = 2'b11;
    tick();
    chk("lk_g0", 32'(gnt), 32'h1);
    chk("lk_we0", 32'(mem_we), 32'd1);
    we = 2'b00; lock = 2'b00;
    tick(); tick();
    chk("lk_ack0", 32'(ack), 32'h1);
    tick();
    chk("lk_g1_owner", 32'(gnt), 32'h1);
    chk("lk_we1", 32'(mem_we), 32'd0);
    req = 2'b10;
    tick(); tick();
    chk("lk_ack1", 32'(ack), 32'h1);
    chk("lk_rdata1", 32'(rdata), 32'hAAAA);
    tick();
    chk("lk_g2_ldr", 32'(gnt), 32'h2);
    req = 2'b00;
    tick(); tick();
    chk("lk_ack2", 32'(ack), 32'h2);
    chk("lk_rdata2", 32'(rdata), 32'hAAAA);

    // Back-to-back writes from requester 1, addrs/data 9..12
    addr1 = 6'd9; wdata1 = 16'd9; we = 2'b10; req = 2'b10;
    last_ack = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("b2b_gnt", 32'(gnt), 32'h2);
      chk("b2b_addr", 32'(mem_addr), 32'(9 + i));
      chk("b2b_wdata", 32'(mem_wdata), 32'(9 + i));
      if (i < 3) begin
        addr1 = 6'(10 + i);
        wdata1 = 16'(10 + i);
      end else begin
        req = 2'b00;
        we = 2'b00;
      end
      tick(); tick();
      chk("b2b_ack", 32'(ack), 32'h2);
      if (i > 0) chk("b2b_spacing", 32'(cyc - last_ack), 32'd3);
      last_ack = cyc;
    end
    for (int i = 0; i < 4; i++) begin
      do_access(1, 1'b0, 6'(9 + i), 16'd0, rd);
      chk("b2b_readback", 32'(rd), 32'(9 + i));
    end

    // Reset during RESP of a read: no ack, rdata cleared
    poke(6'd30, 16'h1234);
    addr0 = 6'd30; we = 2'b00; req = 2'b01;
    tick();
    chk("rr_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    tick();
    reset = 1'b1;
    tick();
    chk("rr_ack", 32'(ack), 32'd0);
    chk("rr_rdata", 32'(rdata), 32'd0);
    reset = 1'b0;
    tick();
    chk("rr_ack_after", 32'(ack), 32'd0);

    // Reset during ISSUE of a write: memory still commits, outputs zeroed
    addr0 = 6'd6; wdata0 = 16'd7; we = 2'b01; req = 2'b01;
    tick();
    chk("rw_mem_en", 32'(mem_en), 32'd1);
    reset = 1'b1; req = 2'b00; we = 2'b00;
    tick();
    chk("rw_gnt", 32'(gnt), 32'd0);
    chk("rw_ack", 32'(ack), 32'd0);
    chk("rw_mem_en0", 32'(mem_en), 32'd0);
    chk("rw_mem_we0", 32'(mem_we), 32'd0);
    chk("rw_mem_addr0", 32'(mem_addr), 32'd0);
    chk("rw_mem_wdata0", 32'(mem_wdata), 32'd0);
    chk("rw_rdata0", 32'(rdata), 32'd0);
    reset = 1'b0;
    chk("rw_mem6", 32'(mem[6]), 32'd7);
    do_access(0, 1'b0, 6'd6, 16'd0, rd);
    chk("rw_readback", 32'(rd), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 64x16 unified instruction/data memory between two requesters.
- Requester 0 is the CPU fetch/operand/stack port. Requester 1 is the program-loader/debug port that preloads code and data and reads back results.
- Round-robin arbitration with an optional lock, so a requester can perform back-to-back accesses such as a stack push followed by a pointer update.
- Sits between the CPU core, the loader and the synchronous-read memory.

Parameters:
- ADDR_W, 6, memory address width (64 words).
- DATA_W, 16, memory word width.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  2  per-requester access request; bit i = requester i.
- lock  in  2  per-requester lock request; sampled together with req.
- we  in  2  per-requester write enable; 1 = write, 0 = read.
- addr0, addr1  in  ADDR_W each  requester addresses.
- wdata0, wdata1  in  DATA_W each  requester write data.
- gnt  out  2  one-hot grant pulse, one cycle long.
- ack  out  2  one-hot completion pulse, one cycle long.
- rdata  out  DATA_W  read data; valid while ack is high and the access was a read.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_en is sampled with mem_we=0.

Behaviour:
- Reset values: gnt=0, ack=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, state=IDLE, last=1 (requester 0 wins the first tie), lock_valid=0.
- All outputs are registered.
- FSM has three states: IDLE, ISSUE, RESP.
- IDLE, no eligible request: outputs stay idle.
- IDLE, with an eligible request, at the clock edge:
  - select a winner;
  - load mem_en=1, mem_we=we[w], mem_addr=addr_w, mem_wdata=wdata_w;
  - set gnt[w]=1 and last=w;
  - if lock[w]=1 then set lock_valid=1 and lock_owner=w, else set lock_valid=0;
  - go to ISSUE.
- ISSUE (exactly 1 cycle): the memory samples the command at the next edge. At that edge clear mem_en, mem_we and gnt, then go to RESP.
- RESP (exactly 1 cycle): at the edge, set ack[w]=1. If the access was a read, load rdata=mem_rdata; a write leaves rdata unchanged. Go to IDLE.
- ack is cleared on the following edge.
- Eligibility when lock_valid=1: only lock_owner is eligible.
- Eligibility when lock_valid=0: all requesters with req=1 are eligible.
- Winner selection:
  - a single eligible requester wins;
  - with both eligible, the winner is the requester != last.
- Lock release:
  - lock_valid clears when the owner is granted with lock=0;
  - lock_valid also clears in IDLE when the owner presents req=0 and lock=0. The owner must present both low to release; no other requester is served while lock_valid=1.
- Requester handshake:
  - hold req, lock, we, addr and wdata stable from raising req until gnt is seen high;
  - req may drop or change the cycle after gnt.
- Latency: a request sampled at edge N gives gnt and the memory command in cycle N+1, and ack in cycle N+3.
- Throughput: one access per 3 cycles.
- Back-to-back: IDLE may arbitrate in the same cycle that ack is high, so a new gnt follows ack immediately.
- A requester raising req in a cycle where it is not granted keeps waiting. No request is dropped.
- Reset mid-operation:
  - a write already in ISSUE at the reset edge still commits, because the memory samples at that edge;
  - an in-flight read is discarded with no ack;
  - lock state is cleared.
- Address width: addresses use the full ADDR_W; there is no range check.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding: IDLE=2'd0, ISSUE=2'd1, RESP=2'd2;
  - requester index constants REQ_CPU=0, REQ_LDR=1;
  - default ADDR_W and DATA_W.
- Sub-module mem_arb_pick: combinational two-way round-robin picker with lock masking.
  - inputs: req, lock_valid, lock_owner, last;
  - outputs: any, winner.

Test Plan:
- Single read: memory[5]=3; requester 0 reads addr 5 → gnt=2'b01 one cycle later, ack=2'b01 two cycles after gnt, rdata=3.
- Write then read: requester 1 writes 16'h0C37 to addr 22, then reads addr 22 → second ack carries rdata=16'h0C37; requester 0 never acked.
- Tie round-robin: both req held high continuously → grants alternate 01,10,01,10; the first grant goes to requester 0 after reset.
- Lock: requester 0 issues lock=1 on a write to addr 0 while requester 1 waits, then a lock=0 read of addr 0 → both requester-0 accesses complete before requester 1 gets gnt.
- Back-to-back: requester 1 streams 4 writes to addrs 9..12 with data 9..12 → ack spacing is 3 cycles; readback returns 9,10,11,12.
- Reset mid-op: reset asserted during RESP of a read → no ack. Reset asserted during ISSUE of a write of 7 to addr 6 → memory[6]=7 afterwards; all outputs 0 the cycle after reset.
